// File: rtl/uart_pkg.sv
// Types and defaults shared by the UART receive bridge and its FIFO.
package uart_pkg;

   typedef logic [7:0] byte_t;

   typedef struct packed {
      logic  valid;
      byte_t data;
   } read_out_t;

   localparam int UART_RX_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop, full/empty flags and an occupancy count.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_RX_DEPTH_DEFAULT,
   parameter int WIDTH = $bits(byte_t),
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem[rd_ptr_q];
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; count_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/uart_rx_bridge.sv
// Buffers bytes from the USB-serial bridge and presents a registered head byte to the core.
// Define UART_RX_DROP_ON_FULL_EN to always accept and count bytes dropped while full.
module uart_rx_bridge
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_RX_DEPTH_DEFAULT,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  byte_t       uart_out_data,
   input  logic        uart_out_valid,
   output logic        uart_out_ready,
   input  logic        ext_uart_read_arg,
   output logic [8:0]  ext_uart_read_out,
   output logic [AW:0] fifo_count,
   output logic [7:0]  overflow_count
);

   read_out_t head_q, head_d;
   byte_t     fifo_head;
   logic      fifo_full, fifo_empty, fifo_push, head_free, refill;

   sync_fifo #(.DEPTH(DEPTH), .WIDTH($bits(byte_t))) u_fifo (
      .clk       (CLK),
      .rst_n     (RST_N),
      .push      (fifo_push),
      .push_data (uart_out_data),
      .pop       (refill),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

`ifdef UART_RX_DROP_ON_FULL_EN
   logic [7:0] ovf_q, ovf_d;

   assign uart_out_ready = RST_N;
   assign overflow_count = ovf_q;

   always_comb begin
      ovf_d = ovf_q;
      if (uart_out_valid && fifo_full && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) ovf_q <= 8'h00;
      else        ovf_q <= ovf_d;
   end
`else
   assign uart_out_ready = RST_N && !fifo_full;
   assign overflow_count = 8'h00;
`endif

   // A byte offered while the FIFO is full never enters it, whichever mode is built.
   assign fifo_push = uart_out_valid && uart_out_ready && !fifo_full;
   assign head_free = !head_q.valid || ext_uart_read_arg;
   assign refill    = head_free && !fifo_empty;

   always_comb begin
      head_d = head_q;
      if (refill) begin
         head_d.valid = 1'b1;
         head_d.data  = fifo_head;
      end else if (head_free) begin
         head_d.valid = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) head_q <= '0;
      else        head_q <= head_d;
   end

   assign ext_uart_read_out = head_q;

endmodule

// File: tb/tb_uart_rx_bridge.sv
// Scoreboard bench for uart_rx_bridge: accepted bytes are queued, popped bytes are compared.
module tb_uart_rx_bridge;
   import uart_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   byte_t       uart_out_data = 8'h00;
   logic        uart_out_valid = 1'b0;
   logic        uart_out_ready;
   logic        ext_uart_read_arg = 1'b0;
   logic [8:0]  ext_uart_read_out;
   logic [AW:0] fifo_count;
   logic [7:0]  overflow_count;

   int    errors = 0;
   int    checks = 0;
   byte_t exp_q[$];

   uart_rx_bridge #(.DEPTH(DEPTH)) dut (
      .CLK               (CLK),
      .RST_N             (RST_N),
      .uart_out_data     (uart_out_data),
      .uart_out_valid    (uart_out_valid),
      .uart_out_ready    (uart_out_ready),
      .ext_uart_read_arg (ext_uart_read_arg),
      .ext_uart_read_out (ext_uart_read_out),
      .fifo_count        (fifo_count),
      .overflow_count    (overflow_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected stream: every byte the bridge accepts, in order. With drop-on-full,
   // the bridge holds at most DEPTH+1 bytes, so anything beyond that is discarded.
   always @(negedge CLK) begin
      if (RST_N && uart_out_valid && uart_out_ready) begin
`ifdef UART_RX_DROP_ON_FULL_EN
         if (exp_q.size() <= DEPTH) exp_q.push_back(uart_out_data);
`else
         exp_q.push_back(uart_out_data);
`endif
      end
   end

   // Monitor: a pop happens at the next edge whenever the head is valid and requested.
   always @(negedge CLK) begin
      #1;
      if (RST_N && ext_uart_read_out[8] && ext_uart_read_arg) begin
         if (exp_q.size() == 0) check("pop_with_empty_model", 32'(exp_q.size()), 32'd1);
         else                   check("pop_data", 32'(ext_uart_read_out[7:0]), 32'(exp_q.pop_front()));
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_byte(input byte_t b);
      logic acc;
      acc = 1'b0;
      uart_out_valid = 1'b1;
      uart_out_data  = b;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge CLK);
         acc = uart_out_ready;
         @(posedge CLK);
         #1;
      end
      uart_out_valid = 1'b0;
      check("push_accept", 32'(acc), 32'd1);
   endtask

   task automatic drain();
      tick();
      ext_uart_read_arg = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (!ext_uart_read_out[8]) break;
         tick();
      end
      ext_uart_read_arg = 1'b0;
      check("drain_head_empty", 32'(ext_uart_read_out[8]), 32'd0);
      check("drain_model_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0]  snap_out;
      logic [AW:0] snap_cnt;

      // Reset values
      #2;
      check("rst_ready_low", 32'(uart_out_ready), 32'd0);
      check("rst_read_out", 32'(ext_uart_read_out), 32'h000);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_overflow", 32'(overflow_count), 32'd0);
      tick();
      tick();
      RST_N = 1'b1;
      tick();
      check("ready_after_reset", 32'(uart_out_ready), 32'd1);

      // Single byte, core idle: visible one edge after the accept edge, not before
      push_byte(8'h41);
      check("no_bypass", 32'(ext_uart_read_out[8]), 32'd0);
      tick();
      check("single_byte_out", 32'(ext_uart_read_out), 32'h141);
      check("single_byte_count", 32'(fifo_count), 32'd0);
      ext_uart_read_arg = 1'b1;
      tick();
      ext_uart_read_arg = 1'b0;
      check("single_byte_popped", 32'(ext_uart_read_out[8]), 32'd0);

      // Back-to-back burst then a held pop: one byte per cycle
      for (int i = 0; i < 5; i++) push_byte(byte_t'(8'h10 + i));
      ext_uart_read_arg = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("burst_head", 32'(ext_uart_read_out), 32'h100 | 32'(8'h10 + i));
         tick();
      end
      ext_uart_read_arg = 1'b0;
      check("burst_done", 32'(ext_uart_read_out[8]), 32'd0);

      // Fill DEPTH+1 with the core idle
      for (int i = 0; i < DEPTH + 1; i++) push_byte(byte_t'(8'h80 + i));
      check("full_count", 32'(fifo_count), 32'(DEPTH));
`ifdef UART_RX_DROP_ON_FULL_EN
      check("full_ready_drop_mode", 32'(uart_out_ready), 32'd1);
`else
      check("full_ready_low", 32'(uart_out_ready), 32'd0);
`endif
      ext_uart_read_arg = 1'b1;
      tick();
      ext_uart_read_arg = 1'b0;
      check("ready_after_pop", 32'(uart_out_ready), 32'd1);
      check("count_after_pop", 32'(fifo_count), 32'(DEPTH - 1));
      drain();

      // Continuous stream across pointer wrap
      ext_uart_read_arg = 1'b1;
      for (int i = 0; i < 40; i++) begin
         push_byte(byte_t'($urandom));
         check("stream_count_le1", 32'(fifo_count <= 1), 32'd1);
      end
      drain();

      // Pop with an empty head is ignored
      snap_out = ext_uart_read_out;
      snap_cnt = fifo_count;
      ext_uart_read_arg = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_pop_out", 32'(ext_uart_read_out), 32'(snap_out));
         check("idle_pop_count", 32'(fifo_count), 32'(snap_cnt));
      end
      ext_uart_read_arg = 1'b0;

      // Asynchronous reset with bytes buffered
      for (int i = 0; i < 5; i++) push_byte(byte_t'(8'hC0 + i));
      #3;
      RST_N = 1'b0;
      #1;
      check("midrst_read_out", 32'(ext_uart_read_out), 32'h000);
      check("midrst_count", 32'(fifo_count), 32'd0);
      check("midrst_ready", 32'(uart_out_ready), 32'd0);
      check("midrst_overflow", 32'(overflow_count), 32'd0);
      exp_q.delete();
      tick();
      tick();
      RST_N = 1'b1;
      tick();
      push_byte(8'hA5);
      tick();
      check("post_rst_out", 32'(ext_uart_read_out), 32'h1A5);
      check("post_rst_count", 32'(fifo_count), 32'd0);
      drain();

`ifdef UART_RX_DROP_ON_FULL_EN
      // Drop-on-full: only the first DEPTH+1 bytes survive
      for (int i = 0; i < 20; i++) push_byte(byte_t'(8'h20 + i));
      check("drop_overflow_count", 32'(overflow_count), 32'd3);
      check("drop_fifo_count", 32'(fifo_count), 32'(DEPTH));
      drain();
`else
      // Randomised traffic: slow consumer then fast consumer
      for (int i = 0; i < 400; i++) begin
         uart_out_valid    = 1'($urandom_range(0, 1));
         uart_out_data     = byte_t'($urandom);
         ext_uart_read_arg = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         tick();
         check("rand_count_bound", 32'(fifo_count <= DEPTH), 32'd1);
      end
      uart_out_valid    = 1'b0;
      ext_uart_read_arg = 1'b0;
      drain();
      check("overflow_tied_zero", 32'(overflow_count), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
